vote_sequencer: RTL and testbench
=================================

VOTE_SEQUENCER -- requirements
Module: vote_sequencer

Interface
REQ-001 Parameter WINDOW, default 16, voting-window length in clk cycles (legal range 2..65535).
REQ-002 Parameter TW, default $clog2(WINDOW), width of the window timer.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to open a new voting session.
REQ-006 vote_valid  input  1  a vote is presented this cycle.
REQ-007 vote_id  input  3  voter index; 0..6 map to voter inputs A1..A7; 7 is illegal.
REQ-008 vote_val  input  1  vote value (1 = yes, 0 = no).
REQ-009 busy  output  1  session open or under evaluation.
REQ-010 voted  output  7  bit i set once voter i has cast a vote in the current session.
REQ-011 yes_count  output  3  number of accepted yes votes in the current session, 0..7.
REQ-012 result_valid  output  1  pass holds a valid decision.
REQ-013 pass  output  1  majority decision: 1 when at least 4 of 7 votes are yes.

Function
REQ-014 The FSM SHALL have four states: IDLE, OPEN, EVAL and DONE.
REQ-015 From IDLE or DONE, start=1 SHALL enter OPEN next cycle, clear voted, vote register and yes_count, clear result_valid, and load timer 0.
REQ-016 start SHALL be ignored in OPEN and EVAL.
REQ-017 In OPEN, a vote with vote_valid=1, vote_id<=6 and voted[vote_id]=0 SHALL be accepted: set voted[vote_id], store vote_val, and increment yes_count when vote_val=1.
REQ-018 Repeat votes from an already-voted id SHALL be ignored (first vote wins), as SHALL votes with vote_id=7 and any vote outside OPEN.
REQ-019 The timer SHALL increment every OPEN cycle; OPEN SHALL close at the end of the cycle in which the timer equals WINDOW-1 or in which voted becomes 7'h7F, whichever comes first.
REQ-020 A valid vote arriving in the closing cycle SHALL be accepted.
REQ-021 Voters that have not voted when OPEN closes SHALL count as 0 (no).
REQ-022 EVAL SHALL last exactly one cycle: the 7-bit vote register drives the majority voter, and pass is registered at the end of EVAL.
REQ-023 Latency: result_valid=1 in the second cycle after the closing cycle, in state DONE.
REQ-024 DONE SHALL hold pass, yes_count, voted and result_valid=1 stable until the next start.
REQ-025 busy SHALL be 1 in OPEN and EVAL, and 0 in IDLE and DONE.
REQ-026 yes_count SHALL never wrap; it is bounded by the 7 one-vote-per-voter rule.
REQ-027 pass SHALL equal (yes_count >= 4) at result_valid; this is an invariant.

Reset
REQ-028 rst=1 SHALL, from any state including mid-session, asynchronously force IDLE, timer=0, vote register=0, voted=0, yes_count=0, result_valid=0, pass=0 and busy=0.
REQ-029 After rst deasserts, the block SHALL ignore votes until a start is seen.

Structure
REQ-030 Package vote_pkg SHALL hold the FSM state enum (IDLE, OPEN, EVAL, DONE) and the constants NUM_VOTERS=7 and MAJORITY=4.
REQ-031 The block SHALL instantiate exactly one sub-module, the existing 7-input majority voter seven (A1..A7 -> OUT), driven from the vote register.
REQ-032 Timer, vote register and counters SHALL be implemented locally; no other sub-modules are used.

Verification
REQ-033 Reset then start; ids 0..3 vote yes and 4..6 vote no on consecutive cycles -> early close after the 7th vote, result_valid 2 cycles later, pass=1, yes_count=4, voted=7F.
REQ-034 Start; ids 0..2 vote yes, no further votes, WINDOW=16 -> close at timer 15, pass=0, yes_count=3, voted=07.
REQ-035 Start; id 2 votes yes twice and no once, id 7 votes yes, others silent -> yes_count=1, voted=04, pass=0.
REQ-036 Start; votes from ids 0..5 yes, id 6 yes arriving exactly at timer=15 -> id 6 accepted, yes_count=7, pass=1.
REQ-037 Assert rst mid-OPEN after 3 yes votes -> all outputs 0 immediately; votes after release are ignored until start.
REQ-038 In DONE with pass=1, assert start together with vote_valid -> that vote is ignored, result_valid=0 next cycle, new session behaves as REQ-033.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg
// Shared definitions for the vote sequencer: the session FSM states, the
// size of the voter panel, the majority threshold and a small bit-count
// helper used by the majority voter.
package vote_pkg;

  localparam int NUM_VOTERS = 7;
  localparam int MAJORITY   = 4;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    EVAL,
    DONE
  } vote_state_t;

  // Number of set bits in a full voter vector (0..7 fits in 3 bits).
  function automatic logic [2:0] count_ones(input logic [NUM_VOTERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/vote_sequencer_if.sv
// vote_sequencer_if
// Bundles the session control, vote input and status/result signals of the
// vote sequencer.
//   master : drives start, vote_valid, vote_id, vote_val; observes status
//   slave  : the sequencer itself; observes the inputs, drives busy, voted,
//            yes_count, result_valid and pass
interface vote_sequencer_if;
  import vote_pkg::*;

  logic                  start;
  logic                  vote_valid;
  logic [2:0]            vote_id;
  logic                  vote_val;
  logic                  busy;
  logic [NUM_VOTERS-1:0] voted;
  logic [2:0]            yes_count;
  logic                  result_valid;
  logic                  pass;

  modport master (
    output start, vote_valid, vote_id, vote_val,
    input  busy, voted, yes_count, result_valid, pass
  );

  modport slave (
    input  start, vote_valid, vote_id, vote_val,
    output busy, voted, yes_count, result_valid, pass
  );

endinterface

// File: rtl/seven.sv
// seven
// Combinational 7-input majority voter.
//   A1..A7 : individual votes (1 = yes)
//   OUT    : 1 when at least MAJORITY of the inputs are set
module seven
  import vote_pkg::*;
(
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic A5,
  input  logic A6,
  input  logic A7,
  output logic OUT
);

  logic [2:0] ones;

  assign ones = count_ones({A7, A6, A5, A4, A3, A2, A1});
  assign OUT  = (ones >= 3'(MAJORITY));

endmodule

// File: rtl/vote_sequencer.sv
// vote_sequencer
// Runs one voting session at a time for a panel of seven voters. A start
// pulse opens a window of WINDOW cycles; each voter's first legal vote is
// recorded, and the window closes early once everyone has voted. After a
// one-cycle evaluation the majority decision is held until the next start.
//   clk, rst : system clock, asynchronous active-high reset
//   vs       : vote_sequencer_if.slave (start/vote inputs, status/result)
module vote_sequencer
  import vote_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int TW     = $clog2(WINDOW)
)
(
  input  logic            clk,
  input  logic            rst,
  vote_sequencer_if.slave vs
);

  vote_state_t           state;
  logic [TW-1:0]         timer;
  logic [NUM_VOTERS-1:0] vote_reg;
  logic [NUM_VOTERS-1:0] voted;
  logic [2:0]            yes_count;
  logic                  result_valid;
  logic                  pass;
  logic                  busy;

  logic                  accept;
  logic [NUM_VOTERS-1:0] vote_mask;
  logic                  closing;
  logic                  maj;

  // A vote counts only while the window is open, for a real voter, and only
  // the first time that voter speaks. The window closes on the last timer
  // value or when this cycle's vote completes the panel; the closing vote
  // itself is still taken.
  always_comb begin
    accept    = 1'b0;
    vote_mask = '0;
    if (state == OPEN && vs.vote_valid && vs.vote_id <= 3'd6) begin
      vote_mask[vs.vote_id] = 1'b1;
      if ((voted & vote_mask) == '0) begin
        accept = 1'b1;
      end else begin
        vote_mask = '0;
      end
    end
    closing = (state == OPEN) &&
              ((timer == TW'(WINDOW - 1)) || ((voted | vote_mask) == '1));
  end

  seven u_seven (
    .A1  (vote_reg[0]),
    .A2  (vote_reg[1]),
    .A3  (vote_reg[2]),
    .A4  (vote_reg[3]),
    .A5  (vote_reg[4]),
    .A6  (vote_reg[5]),
    .A7  (vote_reg[6]),
    .OUT (maj)
  );

  // Session FSM. Absent voters keep their cleared vote_reg bit, so they
  // count as "no" when the voter is sampled in EVAL. pass is left untouched
  // on a new start; result_valid is what qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      vote_reg     <= '0;
      voted        <= '0;
      yes_count    <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (vs.start) begin
            state        <= OPEN;
            timer        <= '0;
            vote_reg     <= '0;
            voted        <= '0;
            yes_count    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b1;
          end
        end
        OPEN: begin
          timer <= timer + TW'(1);
          if (accept) begin
            voted    <= voted | vote_mask;
            vote_reg <= vs.vote_val ? (vote_reg | vote_mask) : vote_reg;
            if (vs.vote_val) begin
              yes_count <= yes_count + 3'd1;
            end
          end
          if (closing) begin
            state <= EVAL;
          end
        end
        EVAL: begin
          pass         <= maj;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign vs.busy         = busy;
  assign vs.voted        = voted;
  assign vs.yes_count    = yes_count;
  assign vs.result_valid = result_valid;
  assign vs.pass         = pass;

endmodule

// File: tb/tb_vote_sequencer.sv
// tb_vote_sequencer
// Self-checking bench for vote_sequencer. Each session is described by a
// per-cycle schedule of inputs; the expected outcome is derived from the
// voting rules (first legal vote per voter, close on window end or full
// panel, decision two cycles after close).
module tb_vote_sequencer;
  import vote_pkg::*;

  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vote_sequencer_if vif ();

  vote_sequencer #(.WINDOW(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .vs  (vif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit         sv   [WIN];
  logic [2:0] sid  [WIN];
  bit         sval [WIN];
  bit         sst  [WIN];

  int firstK [NUM_VOTERS];
  int closeK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit v, input logic [2:0] id,
                               input bit val);
    vif.start      = st;
    vif.vote_valid = v;
    vif.vote_id    = id;
    vif.vote_val   = val;
  endtask

  task automatic clearSched();
    for (int k = 0; k < WIN; k++) begin
      sv[k] = 1'b0; sid[k] = 3'd0; sval[k] = 1'b0; sst[k] = 1'b0;
    end
  endtask

  // Which cycle of the window each voter first speaks in, and when the
  // window closes as a result.
  task automatic buildModel();
    int missing;
    int latest;
    for (int i = 0; i < NUM_VOTERS; i++) firstK[i] = -1;
    for (int k = 0; k < WIN; k++) begin
      if (sv[k] && sid[k] != 3'd7 && firstK[sid[k]] < 0) firstK[sid[k]] = k;
    end
    missing = 0;
    latest  = 0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (firstK[i] < 0) missing++;
      else if (firstK[i] > latest) latest = firstK[i];
    end
    closeK = (missing == 0) ? latest : WIN - 1;
  endtask

  function automatic logic [31:0] expVoted(input int k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (firstK[i] >= 0 && firstK[i] <= k) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int expYes(input int k);
    int n;
    n = 0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (firstK[i] >= 0 && firstK[i] <= k && sval[firstK[i]]) n++;
    end
    return n;
  endfunction

  task automatic runSession(input bit startVote, input string name);
    int yes;
    buildModel();
    yes = expYes(closeK);
    @(negedge clk);
    applyStimulus(1'b1, startVote, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput({name, ".open_rv"},    32'(vif.result_valid), 32'd0);
    checkOutput({name, ".open_busy"},  32'(vif.busy),         32'd1);
    checkOutput({name, ".open_voted"}, 32'(vif.voted),        32'd0);
    checkOutput({name, ".open_yes"},   32'(vif.yes_count),    32'd0);
    for (int k = 0; k <= closeK; k++) begin
      applyStimulus(sst[k], sv[k], sid[k], sval[k]);
      @(negedge clk);
      checkOutput({name, ".voted"}, 32'(vif.voted),     expVoted(k));
      checkOutput({name, ".yes"},   32'(vif.yes_count), 32'(expYes(k)));
      checkOutput({name, ".busy"},  32'(vif.busy),      32'd1);
      checkOutput({name, ".rv"},    32'(vif.result_valid), 32'd0);
    end
    // Evaluation cycle: start and votes here must both be ignored.
    applyStimulus(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
    @(negedge clk);
    for (int h = 0; h < 3; h++) begin
      checkOutput({name, ".done_rv"},    32'(vif.result_valid), 32'd1);
      checkOutput({name, ".done_busy"},  32'(vif.busy),         32'd0);
      checkOutput({name, ".done_pass"},  32'(vif.pass),         32'(yes >= MAJORITY));
      checkOutput({name, ".done_yes"},   32'(vif.yes_count),    32'(yes));
      checkOutput({name, ".done_voted"}, 32'(vif.voted),        expVoted(closeK));
      applyStimulus(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    int density;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.busy",  32'(vif.busy),         32'd0);
    checkOutput("reset.voted", 32'(vif.voted),        32'd0);
    checkOutput("reset.yes",   32'(vif.yes_count),    32'd0);
    checkOutput("reset.rv",    32'(vif.result_valid), 32'd0);
    checkOutput("reset.pass",  32'(vif.pass),         32'd0);
    rst = 1'b0;

    // Votes before any start are ignored.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 3'(k), 1'b1);
      @(negedge clk);
      checkOutput("idle.voted", 32'(vif.voted), 32'd0);
      checkOutput("idle.busy",  32'(vif.busy),  32'd0);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);

    // Four yes then three no back to back: early close, pass.
    clearSched();
    for (int k = 0; k < 7; k++) begin
      sv[k] = 1'b1; sid[k] = 3'(k); sval[k] = (k < 4);
    end
    runSession(1'b0, "early");

    // Three yes then silence: runs the full window, fail.
    clearSched();
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b1; sid[k] = 3'(k); sval[k] = 1'b1;
    end
    runSession(1'b0, "timeout");

    // Repeat votes and the illegal id are discarded.
    clearSched();
    sv[0] = 1'b1; sid[0] = 3'd2; sval[0] = 1'b1;
    sv[1] = 1'b1; sid[1] = 3'd2; sval[1] = 1'b1;
    sv[2] = 1'b1; sid[2] = 3'd2; sval[2] = 1'b0;
    sv[3] = 1'b1; sid[3] = 3'd7; sval[3] = 1'b1;
    runSession(1'b0, "repeat");

    // Last voter arrives on the final window cycle and is still counted.
    clearSched();
    for (int k = 0; k < 6; k++) begin
      sv[k] = 1'b1; sid[k] = 3'(k); sval[k] = 1'b1;
    end
    sv[WIN-1] = 1'b1; sid[WIN-1] = 3'd6; sval[WIN-1] = 1'b1;
    runSession(1'b0, "lastcycle");

    // Restart from a passing result with a vote alongside start.
    clearSched();
    for (int k = 0; k < 7; k++) begin
      sv[k] = 1'b1; sid[k] = 3'(k); sval[k] = (k < 4);
    end
    runSession(1'b1, "restart");

    // Reset in the middle of an open window.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 3'(k), 1'b1);
      @(negedge clk);
    end
    checkOutput("midrst.pre_yes", 32'(vif.yes_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.busy",  32'(vif.busy),         32'd0);
    checkOutput("midrst.voted", 32'(vif.voted),        32'd0);
    checkOutput("midrst.yes",   32'(vif.yes_count),    32'd0);
    checkOutput("midrst.rv",    32'(vif.result_valid), 32'd0);
    checkOutput("midrst.pass",  32'(vif.pass),         32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 3; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 3'(k), 1'b1);
      @(negedge clk);
      checkOutput("postrst.voted", 32'(vif.voted),     32'd0);
      checkOutput("postrst.yes",   32'(vif.yes_count), 32'd0);
      checkOutput("postrst.busy",  32'(vif.busy),      32'd0);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);

    // Randomized sessions with mixed densities and stray start pulses.
    for (int s = 0; s < 25; s++) begin
      clearSched();
      density = int'($urandom_range(15, 90));
      for (int k = 0; k < WIN; k++) begin
        sv[k]   = (int'($urandom_range(0, 99)) < density);
        sid[k]  = 3'($urandom_range(0, 7));
        sval[k] = 1'($urandom_range(0, 1));
        sst[k]  = ($urandom_range(0, 7) == 0);
      end
      runSession(1'($urandom_range(0, 1)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
